// File: rtl/adf4351_reg_seq.sv
// ADF4351 register sequencer: shadows R0..R5, streams them to the SPI write
// controller in R5..R0 (or R1,R0) order, then waits for PLL lock detect.
module adf4351_reg_seq #(
   parameter int unsigned GAP_CYCLES = 16,
   parameter int unsigned WR_TIMEOUT = 255,
   parameter int unsigned LD_TIMEOUT = 400000,
   parameter int unsigned LD_STABLE  = 64
) (
   input  logic        sys_clk,
   input  logic        rst,
   input  logic        cfg_we,
   input  logic [2:0]  cfg_addr,
   input  logic [31:0] cfg_wdata,
   input  logic        start,
   input  logic        quick,
   input  logic        pll_ld,
   input  logic        update_vld,
   output logic [31:0] wr_spi_data,
   output logic        wr_en,
   output logic        busy,
   output logic        done,
   output logic        lock_ok,
   output logic [1:0]  err
);
   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam int AW = $clog2(WR_TIMEOUT + 1);
   localparam int TW = $clog2(LD_TIMEOUT + 1);
   localparam int SW = $clog2(LD_STABLE + 1);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, GAP, LD_WAIT, DONE} state_t;
   state_t state, state_nx;

   logic [31:0]   shadow [6];
   logic [2:0]    idx;
   logic [GW-1:0] gap_cnt;
   logic [AW-1:0] ack_cnt;
   logic [TW-1:0] tot_cnt;
   logic [SW-1:0] stab_cnt;
   logic          ld_meta, ld_sync;
   logic          ack_to, gap_end, lock_hit, ld_to;
   logic [31:0]   cfg_word;

   assign ack_to   = (ack_cnt  == AW'(WR_TIMEOUT));
   assign gap_end  = (gap_cnt  == GW'(GAP_CYCLES - 1));
   assign lock_hit = (stab_cnt == SW'(LD_STABLE));
   assign ld_to    = (tot_cnt  == TW'(LD_TIMEOUT));
   // Low three bits always carry the register address the ADF4351 decodes.
   assign cfg_word = (cfg_wdata & ~32'd7) | {29'd0, cfg_addr};

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:     if (start) state_nx = ISSUE;
         ISSUE:    state_nx = WAIT_ACK;
         WAIT_ACK: if (update_vld)  state_nx = (idx == 3'd0) ? LD_WAIT : GAP;
                   else if (ack_to) state_nx = DONE;
         GAP:      if (gap_end) state_nx = ISSUE;
         LD_WAIT:  if (lock_hit || ld_to) state_nx = DONE;
         DONE:     state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         for (int i = 0; i < 6; i++) shadow[i] <= 32'(i);
         idx         <= '0;
         gap_cnt     <= '0;
         ack_cnt     <= '0;
         tot_cnt     <= '0;
         stab_cnt    <= '0;
         ld_meta     <= 1'b0;
         ld_sync     <= 1'b0;
         wr_spi_data <= '0;
         wr_en       <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         lock_ok     <= 1'b0;
         err         <= 2'b00;
      end else begin
         state   <= state_nx;
         ld_meta <= pll_ld;
         ld_sync <= ld_meta;
         wr_en   <= 1'b0;
         done    <= 1'b0;
         case (state)
            IDLE: begin
               if (cfg_we && cfg_addr < 3'd6) shadow[cfg_addr] <= cfg_word;
               if (start) begin
                  busy    <= 1'b1;
                  err     <= 2'b00;
                  lock_ok <= 1'b0;
                  idx     <= quick ? 3'd1 : 3'd5;
               end
            end
            // Data stays put afterwards; the SPI controller latches it late.
            ISSUE: begin
               wr_en       <= 1'b1;
               wr_spi_data <= shadow[idx];
               ack_cnt     <= '0;
            end
            WAIT_ACK: begin
               if (update_vld) begin
                  if (idx != 3'd0) idx <= idx - 3'd1;
                  gap_cnt  <= '0;
                  tot_cnt  <= '0;
                  stab_cnt <= '0;
               end else if (ack_to) begin
                  err[0] <= 1'b1;
                  done   <= 1'b1;
               end else begin
                  ack_cnt <= ack_cnt + AW'(1);
               end
            end
            GAP: if (!gap_end) gap_cnt <= gap_cnt + GW'(1);
            LD_WAIT: begin
               if (lock_hit) begin
                  lock_ok <= 1'b1;
                  done    <= 1'b1;
               end else if (ld_to) begin
                  err[1]  <= 1'b1;
                  lock_ok <= 1'b0;
                  done    <= 1'b1;
               end else begin
                  tot_cnt  <= tot_cnt + TW'(1);
                  stab_cnt <= ld_sync ? stab_cnt + SW'(1) : '0;
               end
            end
            DONE: busy <= 1'b0;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_adf4351_reg_seq.sv
// Randomized self-checking bench for adf4351_reg_seq: a word-order/timing model
// plus an SPI responder, compared against the DUT every cycle.
module tb_adf4351_reg_seq;
   localparam int GAP = 4, WRT = 100, LDT = 500, LDS = 16;

   logic        sys_clk = 0, rst = 1, cfg_we = 0, start = 0, quick = 0;
   logic        pll_ld = 0, update_vld = 0;
   logic [2:0]  cfg_addr = 0;
   logic [31:0] cfg_wdata = 0;
   logic [31:0] wr_spi_data;
   logic        wr_en, busy, done, lock_ok;
   logic [1:0]  err;

   adf4351_reg_seq #(.GAP_CYCLES(GAP), .WR_TIMEOUT(WRT), .LD_TIMEOUT(LDT), .LD_STABLE(LDS)) dut (
      .sys_clk(sys_clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .start(start), .quick(quick), .pll_ld(pll_ld), .update_vld(update_vld),
      .wr_spi_data(wr_spi_data), .wr_en(wr_en), .busy(busy), .done(done),
      .lock_ok(lock_ok), .err(err));

   always #5 sys_clk = ~sys_clk;
   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   // model state
   logic [31:0] mdl_sh [6];
   logic [31:0] exp_q [$];
   int start_cyc = -1, end_cyc = 0, seq_wr = 0, first_wr = -1;
   int last_vld = -1, last_wr = -1, done_cyc = -1, done_cnt = 0;
   int ack_at = -1, withhold = 0, dly_lo = 2, dly_hi = 80;
   logic prev_wr = 0, prev_done = 0;
   logic [31:0] prev_data = 0;
   int checks = 0, failures = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   always @(negedge sys_clk) begin : mon
      logic eb;
      if (rst) begin
         update_vld = 0;
         prev_wr = 0; prev_done = 0; prev_data = wr_spi_data;
      end else begin
         eb = (start_cyc >= 0) && (cyc > start_cyc) && (cyc <= end_cyc);
         chk("busy", busy, eb);
         if (wr_en) begin
            chk("wr_en_single", prev_wr, 0);
            chk("wr_en_in_busy", eb, 1);
            chk("wr_en_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk("wr_data", wr_spi_data, exp_q.pop_front());
            if (seq_wr == 0) first_wr = cyc;
            else begin
               chk("gap_min", (cyc - last_vld) >= GAP + 1, 1);
               chk("gap_max", (cyc - last_vld) <= GAP + 3, 1);
            end
            seq_wr++;
            last_wr = cyc;
            ack_at = (seq_wr == withhold) ? -1 : cyc + int'($urandom_range(dly_hi, dly_lo));
         end else begin
            chk("data_hold", wr_spi_data, prev_data);
         end
         update_vld = (cyc == ack_at);
         if (update_vld) begin last_vld = cyc; ack_at = -1; end
         if (done) begin
            chk("done_single", prev_done, 0);
            done_cnt++; done_cyc = cyc; end_cyc = cyc;
         end
         prev_wr = wr_en; prev_done = done; prev_data = wr_spi_data;
      end
   end

   task automatic drive(input logic we, input logic [2:0] a, input logic [31:0] d,
                        input logic st, input logic q, input logic idle);
      @(negedge sys_clk);
      cfg_we = we; cfg_addr = a; cfg_wdata = d; start = st; quick = q;
      if (idle && we && a < 6) mdl_sh[a] = {d[31:3], a};
      if (idle && st) begin
         exp_q.delete();
         for (int i = (q ? 1 : 5); i >= 0; i--) exp_q.push_back(mdl_sh[i]);
         seq_wr = 0; first_wr = -1; start_cyc = cyc; end_cyc = 32'h3fff_ffff;
         last_vld = -1; last_wr = -1;
      end
      @(negedge sys_clk);
      cfg_we = 0; start = 0;
   endtask

   task automatic wait_done(input int budget, input bit tog);
      int n = 0, run = 0, d0 = done_cnt;
      while (done_cnt == d0 && n < budget) begin
         @(negedge sys_clk);
         n++;
         if (tog) begin
            if (run == 0) begin
               pll_ld = ~pll_ld;
               run = pll_ld ? int'($urandom_range(LDS - 2, 1)) : int'($urandom_range(4, 1));
            end
            run--;
         end
      end
      chk("done_within_budget", done_cnt > d0, 1);
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   initial begin
      int d0;
      for (int i = 0; i < 6; i++) mdl_sh[i] = 32'(i);
      idle_cycles(2);
      chk("rst_data", wr_spi_data, 0); chk("rst_wr_en", wr_en, 0); chk("rst_busy", busy, 0);
      chk("rst_done", done, 0); chk("rst_lock", lock_ok, 0); chk("rst_err", err, 0);
      rst = 0;
      pll_ld = 1;

      // full sequence with fixed 80-cycle acks and known words
      for (int i = 0; i < 6; i++) drive(1, 3'(i), 32'hA5A5_A5A8, 0, 0, 1);
      chk("pin_r5", mdl_sh[5], 32'hA5A5_A5AD);
      chk("pin_r0", mdl_sh[0], 32'hA5A5_A5A8);
      dly_lo = 80; dly_hi = 80;
      drive(0, 0, 0, 1, 0, 1);
      wait_done(5000, 0);
      chk("full_writes", seq_wr, 6);
      chk("full_first_latency", first_wr - start_cyc, 2);
      chk("full_lock", lock_ok, 1);
      chk("full_err", err, 0);
      chk("full_done_timing", done_cyc - last_vld, LDS + 2);
      idle_cycles(10);
      chk("lock_persist", lock_ok, 1);

      // quick sequence
      dly_lo = 2; dly_hi = 60;
      d0 = done_cnt;
      drive(0, 0, 0, 1, 1, 1);
      wait_done(5000, 0);
      idle_cycles(20);
      chk("quick_writes", seq_wr, 2);
      chk("quick_done_once", done_cnt - d0, 1);
      chk("quick_lock", lock_ok, 1);

      // SPI ack withheld on the 3rd write
      withhold = 3;
      drive(0, 0, 0, 1, 0, 1);
      wait_done(5000, 0);
      chk("ackto_err", err, 2'b01);
      chk("ackto_lock", lock_ok, 0);
      chk("ackto_timing", done_cyc - last_wr, WRT + 1);
      idle_cycles(30);
      chk("ackto_no_more_wr", seq_wr, 3);
      chk("ackto_skipped", exp_q.size(), 3);
      withhold = 0;
      exp_q.delete();

      // lock detect held low
      pll_ld = 0;
      drive(0, 0, 0, 1, 1, 1);
      wait_done(5000, 0);
      chk("ldto_err", err, 2'b10);
      chk("ldto_lock", lock_ok, 0);
      chk("ldto_timing", done_cyc - last_vld, LDT + 2);
      idle_cycles(10);
      chk("err_persist", err, 2'b10);

      // lock detect chattering with short high runs
      drive(0, 0, 0, 1, 1, 1);
      wait_done(5000, 1);
      chk("chatter_err", err, 2'b10);
      chk("chatter_lock", lock_ok, 0);
      pll_ld = 1;
      idle_cycles(5);

      // cfg_we + start while busy are ignored
      d0 = done_cnt;
      drive(0, 0, 0, 1, 0, 1);
      begin
         int n = 0;
         while (seq_wr < 2 && n < 3000) begin @(negedge sys_clk); n++; end
         chk("busy_reach_wr2", seq_wr >= 2, 1);
      end
      drive(1, 3'd2, $urandom, 1, 1, 0);
      wait_done(5000, 0);
      idle_cycles(20);
      chk("busy_no_restart", seq_wr, 6);
      chk("busy_done_once", done_cnt - d0, 1);
      drive(0, 0, 0, 1, 0, 1);
      wait_done(5000, 0);
      chk("busy_shadow_kept", exp_q.size(), 0);

      // cfg_we + start in the same idle cycle
      drive(1, 3'd1, $urandom, 1, 1, 1);
      wait_done(5000, 0);
      chk("same_cycle_sent", exp_q.size(), 0);
      chk("same_cycle_lock", lock_ok, 1);

      // randomized sequences
      for (int it = 0; it < 6; it++) begin
         repeat ($urandom_range(4, 0)) drive(1, 3'($urandom_range(7, 0)), $urandom, 0, 0, 1);
         drive(0, 0, 0, 1, 1'($urandom_range(1, 0)), 1);
         wait_done(5000, 0);
         chk("rand_lock", lock_ok, 1);
         chk("rand_err", err, 0);
         chk("rand_all_sent", exp_q.size(), 0);
      end

      // reset during GAP after the 4th write
      drive(0, 0, 0, 1, 0, 1);
      begin
         int n = 0;
         while (!(seq_wr == 4 && last_vld > last_wr) && n < 3000) begin @(negedge sys_clk); n++; end
         chk("rst_reach_gap4", seq_wr == 4 && last_vld > last_wr, 1);
      end
      idle_cycles(2);
      rst = 1;
      #1;
      chk("midrst_wr_en", wr_en, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_data", wr_spi_data, 0);
      for (int i = 0; i < 6; i++) mdl_sh[i] = 32'(i);
      exp_q.delete(); start_cyc = -1; ack_at = -1; seq_wr = 0;
      idle_cycles(3);
      rst = 0;
      idle_cycles(2);
      chk("pin_rst_r3", mdl_sh[3], 32'd3);
      drive(0, 0, 0, 1, 0, 1);
      wait_done(5000, 0);
      chk("postrst_writes", seq_wr, 6);
      chk("postrst_all_sent", exp_q.size(), 0);
      chk("postrst_lock", lock_ok, 1);

      idle_cycles(5);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
